// File: rtl/tcp_tx_pkt_queue.sv
// Packet FIFO between the TCP TX protocol-calculation stage and packet assembly.
// Define TCP_TX_PKT_QUEUE_STATS_EN to build the packet/byte statistics counters.

`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif

package tcp_tx_pkt_queue_pkg;
    parameter int FLOWID_W = 10;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
    } tcp_pkt_hdr;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
    } payload_buf_struct;
endpackage

module tcp_tx_pkt_queue
    import tcp_tx_pkt_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          proto_calc_tx_queue_val,
    output logic                          proto_calc_tx_queue_rdy,
    input  tcp_pkt_hdr                    proto_calc_tx_pkt_hdr,
    input  logic [FLOWID_W-1:0]           proto_calc_tx_flowid,
    input  logic [`IP_ADDR_W-1:0]         proto_calc_tx_src_ip_addr,
    input  logic [`IP_ADDR_W-1:0]         proto_calc_tx_dst_ip_addr,
    input  payload_buf_struct             proto_calc_tx_payload,
    output logic                          tx_queue_assembler_val,
    input  logic                          tx_queue_assembler_rdy,
    output tcp_pkt_hdr                    tx_queue_assembler_pkt_hdr,
    output logic [FLOWID_W-1:0]           tx_queue_assembler_flowid,
    output logic [`IP_ADDR_W-1:0]         tx_queue_assembler_src_ip_addr,
    output logic [`IP_ADDR_W-1:0]         tx_queue_assembler_dst_ip_addr,
    output payload_buf_struct             tx_queue_assembler_payload,
    output logic [$clog2(DEPTH):0]        tx_queue_occupancy,
    input  logic                          tx_queue_stats_clr,
    output logic [CNT_W-1:0]              tx_queue_pkt_cnt,
    output logic [CNT_W-1:0]              tx_queue_byte_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        tcp_pkt_hdr              hdr;
        logic [FLOWID_W-1:0]     flowid;
        logic [`IP_ADDR_W-1:0]   src_ip;
        logic [`IP_ADDR_W-1:0]   dst_ip;
        payload_buf_struct       payload;
    } entry_t;

    entry_t         mem_r [DEPTH];
    entry_t         head_s;
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic [AW:0]    occ_r;
    logic           full_s;
    logic           empty_s;
    logic           push_s;
    logic           pop_s;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = proto_calc_tx_queue_val & ~full_s;
    assign pop_s   = tx_queue_assembler_rdy & ~empty_s;

    assign proto_calc_tx_queue_rdy = ~full_s;
    assign tx_queue_assembler_val  = ~empty_s;
    assign tx_queue_occupancy      = occ_r;

    assign head_s                         = mem_r[rd_ptr_r[AW-1:0]];
    assign tx_queue_assembler_pkt_hdr     = head_s.hdr;
    assign tx_queue_assembler_flowid      = head_s.flowid;
    assign tx_queue_assembler_src_ip_addr = head_s.src_ip;
    assign tx_queue_assembler_dst_ip_addr = head_s.dst_ip;
    assign tx_queue_assembler_payload     = head_s.payload;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= '{hdr:     proto_calc_tx_pkt_hdr,
                                         flowid:  proto_calc_tx_flowid,
                                         src_ip:  proto_calc_tx_src_ip_addr,
                                         dst_ip:  proto_calc_tx_dst_ip_addr,
                                         payload: proto_calc_tx_payload};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            occ_r    <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + {{AW{1'b0}}, 1'b1};
                2'b01:   occ_r <= occ_r - {{AW{1'b0}}, 1'b1};
                default: occ_r <= occ_r;
            endcase
        end
    end

`ifdef TCP_TX_PKT_QUEUE_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_r;
    logic [CNT_W-1:0] byte_cnt_r;

    // Statistics; a clear wins over a coincident push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_r  <= {CNT_W{1'b0}};
            byte_cnt_r <= {CNT_W{1'b0}};
        end else if (tx_queue_stats_clr) begin
            pkt_cnt_r  <= {CNT_W{1'b0}};
            byte_cnt_r <= {CNT_W{1'b0}};
        end else if (push_s) begin
            pkt_cnt_r  <= pkt_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            byte_cnt_r <= byte_cnt_r + CNT_W'(proto_calc_tx_payload.len);
        end else begin
            pkt_cnt_r  <= pkt_cnt_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

    assign tx_queue_pkt_cnt  = pkt_cnt_r;
    assign tx_queue_byte_cnt = byte_cnt_r;
`else
    logic unused_stats_clr_s;

    assign unused_stats_clr_s = tx_queue_stats_clr;
    assign tx_queue_pkt_cnt   = {CNT_W{1'b0}};
    assign tx_queue_byte_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/tcp_tx_pkt_queue.md
# tcp_tx_pkt_queue

Decoupling FIFO between the TCP TX protocol-calculation stage and the downstream packet assembly/payload fetch stage. Each entry is one produced packet: TCP header, flow ID, source/destination IP, and payload buffer descriptor. The queue absorbs assembly-stage stalls so the protocol stage can keep issuing scheduler updates. Optional statistics counters track enqueued packets and payload bytes.

## Interface
- DEPTH, 8, entries; power of two, ≥2
- CNT_W, 32, statistics counter width
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (asserted at 0)
- proto_calc_tx_queue_val  in  1  input entry valid
- proto_calc_tx_queue_rdy  out  1  queue can accept
- proto_calc_tx_pkt_hdr  in  $bits(tcp_pkt_hdr)  TCP header
- proto_calc_tx_flowid  in  FLOWID_W  flow ID
- proto_calc_tx_src_ip_addr  in  `IP_ADDR_W  source IP
- proto_calc_tx_dst_ip_addr  in  `IP_ADDR_W  destination IP
- proto_calc_tx_payload  in  $bits(payload_buf_struct)  payload addr/len
- tx_queue_assembler_val  out  1  head entry valid
- tx_queue_assembler_rdy  in  1  consumer accepts head
- tx_queue_assembler_pkt_hdr / _flowid / _src_ip_addr / _dst_ip_addr / _payload  out  same widths as inputs  head entry fields
- tx_queue_occupancy  out  $clog2(DEPTH)+1  current entry count
- tx_queue_stats_clr  in  1  synchronous clear of statistics
- tx_queue_pkt_cnt  out  CNT_W  packets enqueued
- tx_queue_byte_cnt  out  CNT_W  payload bytes enqueued

## Operation
- Storage: DEPTH-entry circular buffer. Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- Push: on proto_calc_tx_queue_val & proto_calc_tx_queue_rdy. Write all five fields at the write pointer, then increment it.
- Pop: on tx_queue_assembler_val & tx_queue_assembler_rdy. Increment the read pointer.
- proto_calc_tx_queue_rdy = !full, driven from registered state only.
  - A pop in the same cycle does not make a full queue accept. There is no combinational rdy→rdy path.
- tx_queue_assembler_val = !empty. Output fields show the entry at the read pointer.
  - Fields are don't-care while val=0.
  - Fields hold stable while val=1 & rdy=0.
- Simultaneous push and pop on a non-full, non-empty queue: occupancy unchanged, both pointers advance.
- Simultaneous push and pop on an empty queue: only the push takes effect. The pop is impossible because val=0.
- Occupancy: registered, +1 on push only, −1 on pop only, unchanged otherwise. Range is 0..DEPTH.
- Zero-length payloads (pure ACKs) are queued like any other entry.
- Statistics (see Configuration):
  - Push: pkt_cnt += 1, byte_cnt += payload_len (zero-extended).
  - Both counters wrap modulo 2^CNT_W.
  - stats_clr has priority. A push in the same cycle as a clear is not counted.

## Timing
- Latency: an entry pushed in cycle N is visible on the output with val=1 in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained.
- Reset (rst=0, asynchronous):
  - Pointers 0, occupancy 0.
  - tx_queue_assembler_val=0, proto_calc_tx_queue_rdy=1.
  - pkt_cnt=0, byte_cnt=0.
  - Storage array is not reset.
- Reset mid-operation: all queued entries are discarded immediately. The first post-reset push is the first entry seen.

## Configuration
- TCP_TX_PKT_QUEUE_STATS_EN defined: pkt_cnt/byte_cnt flops are instantiated and behave as described; stats_clr is honoured.
- Not defined: no counter flops are instantiated. tx_queue_pkt_cnt and tx_queue_byte_cnt are tied to 0, stats_clr is ignored, and ports remain present.

## Test plan
- Fill and drain:
  - With assembler rdy=0, push 8 entries (flowid 0..7): rdy drops after the 8th and occupancy=8.
  - Assert rdy=1: flowids 0..7 are popped in order, one per cycle, then val=0 and occupancy=0.
- Full + simultaneous pop: when full, hold in val=1 and out rdy=1.
  - In the first cycle there is no push, 7 remain, and rdy rises.
  - From the next cycle, push and pop each cycle with occupancy steady at 7.
- Wrap-around: with DEPTH=8, stream 20 entries with random out-rdy (50%). All 20 arrive in order with no duplication; the payload address/length and header seq_num of each match the corresponding input.
- Backpressure stability: hold out rdy=0 for 5 cycles with val=1. The head fields are unchanged in every cycle.
- Async reset: push 3 entries, then pulse rst=0 mid-cycle.
  - val falls without waiting for a clock edge, occupancy=0, rdy=1.
  - A new entry with flowid 5 emerges first.
- Stats with the macro defined: push lengths 0, 100, 1460 → pkt_cnt=3, byte_cnt=1560. A stats_clr concurrent with a push of 40 gives 0/0. Without the macro, both counters stay 0 throughout.
